bcd_updown_counter_n: RTL and testbench

- Parametrised, fully synchronous multi-digit BCD counter. It succeeds the single-digit ripple BCD up-counter.
- Adds:
  - DIGITS-wide decade chaining
  - up/down counting
  - count enable
  - parallel load with BCD validity checking
  - wrap (carry/borrow) pulse
  - combinational terminal-count output
- Used as the decade counter for display/timer blocks. Several instances are cascaded through en/tc.

---
 rtl/bcd_updown_counter_n.sv | 66 ++++++
 tb/tb_bcd_updown_counter_n.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit synchronous BCD up/down counter with parallel load, wrap pulse
// and combinational terminal count for zero-latency cascading through en/tc.
module bcd_updown_counter_n #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d_in,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [4*DIGITS-1:0] q_cnt;
  logic                d_valid;
  logic                prop;
  logic [3:0]          dig;
  logic                at_top;
  logic                at_bot;

  // prop is true while every lower decade sits at its rollover value
  always_comb begin
    q_cnt   = q;
    d_valid = 1'b1;
    prop    = 1'b1;
    dig     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (d_in[4*i +: 4] > 4'd9) d_valid = 1'b0;
      dig = q[4*i +: 4];
      if (prop) begin
        if (up_dn) q_cnt[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        else       q_cnt[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
      prop = prop & (up_dn ? (dig == 4'd9) : (dig == 4'd0));
    end
  end

  assign at_top = (q == ALL_NINES);
  assign at_bot = (q == '0);
  assign tc     = en & (up_dn ? at_top : at_bot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (d_valid) q <= d_in;
        else         load_err <= 1'b1;
      end else if (en) begin
        q    <= q_cnt;
        wrap <= up_dn ? at_top : at_bot;
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: integer reference model checked every cycle,
// directed literal scenarios, two-stage cascade and randomized traffic.
module tb_bcd_updown_counter_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        en [2];
  logic        up [2];
  logic        ld [2];
  logic [15:0] din [2];
  logic [15:0] q4;
  logic [7:0]  q2;
  logic        tcs [2];
  logic        wr [2];
  logic        le [2];

  logic        c_en;
  logic [3:0]  lo_q, hi_q;
  logic        lo_tc, hi_tc, lo_wr, hi_wr, lo_le, hi_le;

  int n_chk = 0;
  int n_fail = 0;
  bit run = 0;

  int mv [2];
  bit mw [2];
  bit ml [2];

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en[0]), .up_dn(up[0]), .load(ld[0]), .d_in(din[0]),
    .q(q4), .tc(tcs[0]), .wrap(wr[0]), .load_err(le[0]));

  bcd_updown_counter_n #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en[1]), .up_dn(up[1]), .load(ld[1]), .d_in(din[1][7:0]),
    .q(q2), .tc(tcs[1]), .wrap(wr[1]), .load_err(le[1]));

  bcd_updown_counter_n #(.DIGITS(1)) lo (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .load(1'b0), .d_in(4'h0),
    .q(lo_q), .tc(lo_tc), .wrap(lo_wr), .load_err(lo_le));

  bcd_updown_counter_n #(.DIGITS(1)) hi (
    .clk(clk), .rst(rst), .en(lo_tc), .up_dn(1'b1), .load(1'b0), .d_in(4'h0),
    .q(hi_q), .tc(hi_tc), .wrap(hi_wr), .load_err(hi_le));

  function automatic int nd(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int md(input int k);
    return (k == 0) ? 10000 : 100;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v, input int d);
    for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  function automatic int from_bcd(input logic [15:0] v, input int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v, input int d);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: counter value as a plain integer modulo 10^DIGITS
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mv[k] <= 0;
        mw[k] <= 1'b0;
        ml[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mw[k] <= 1'b0;
        ml[k] <= 1'b0;
        if (ld[k]) begin
          if (bcd_ok(din[k], nd(k))) mv[k] <= from_bcd(din[k], nd(k));
          else                       ml[k] <= 1'b1;
        end else if (en[k]) begin
          if (up[k]) begin
            mv[k] <= (mv[k] + 1) % md(k);
            mw[k] <= (mv[k] == md(k) - 1);
          end else begin
            mv[k] <= (mv[k] + md(k) - 1) % md(k);
            mw[k] <= (mv[k] == 0);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        logic [15:0] qa;
        bit          tce;
        qa  = (k == 0) ? q4 : {8'h00, q2};
        tce = en[k] & (up[k] ? (mv[k] == md(k) - 1) : (mv[k] == 0));
        check(k == 0 ? "model_q4" : "model_q2", 32'(qa), 32'(to_bcd(mv[k], nd(k))));
        check(k == 0 ? "model_tc4" : "model_tc2", 32'(tcs[k]), 32'(tce));
        check(k == 0 ? "model_wrap4" : "model_wrap2", 32'(wr[k]), 32'(mw[k]));
        check(k == 0 ? "model_lerr4" : "model_lerr2", 32'(le[k]), 32'(ml[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int hw_cnt;
    rst = 1'b1;
    c_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; up[k] = 1'b1; ld[k] = 1'b0; din[k] = '0;
    end
    #1 run = 1;
    repeat (2) tick();
    rst = 1'b0;

    // asynchronous reset mid-cycle, then hold
    ld[0] = 1'b1; din[0] = 16'h0437;
    tick();
    check("load_0437", 32'(q4), 32'h0437);
    ld[0] = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_q", 32'(q4), 32'h0);
    check("async_rst_wrap", 32'(wr[0]), 32'h0);
    check("async_rst_lerr", 32'(le[0]), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_zero", 32'(q4), 32'h0);
    end

    // up count with decade carry
    ld[1] = 1'b1; din[1] = 16'h0008;
    tick();
    check("load_08", 32'(q2), 32'h08);
    ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b1;
    tick(); check("up_09", 32'(q2), 32'h09); check("up_09_wrap", 32'(wr[1]), 32'h0);
    tick(); check("up_10", 32'(q2), 32'h10); check("up_10_wrap", 32'(wr[1]), 32'h0);
    tick(); check("up_11", 32'(q2), 32'h11); check("up_11_tc", 32'(tcs[1]), 32'h0);

    // up wrap
    en[1] = 1'b0; ld[1] = 1'b1; din[1] = 16'h0098;
    tick();
    ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b1;
    #1 check("up_98_tc", 32'(tcs[1]), 32'h0);
    tick(); check("up_99", 32'(q2), 32'h99); check("up_99_tc", 32'(tcs[1]), 32'h1);
    tick(); check("up_wrap_q", 32'(q2), 32'h00); check("up_wrap_pulse", 32'(wr[1]), 32'h1);
    tick(); check("up_01", 32'(q2), 32'h01); check("up_wrap_clear", 32'(wr[1]), 32'h0);

    // down with borrow and wrap
    en[1] = 1'b0; ld[1] = 1'b1; din[1] = 16'h0010;
    tick();
    ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b0;
    for (int j = 9; j >= 0; j--) begin
      tick();
      check("down_seq", 32'(q2), 32'(to_bcd(j, 2)));
    end
    check("down_00_tc", 32'(tcs[1]), 32'h1);
    tick(); check("down_wrap_q", 32'(q2), 32'h99); check("down_wrap_pulse", 32'(wr[1]), 32'h1);
    tick(); check("down_98", 32'(q2), 32'h98); check("down_wrap_clear", 32'(wr[1]), 32'h0);
    en[1] = 1'b0;

    // load priority over enable, then rejected load
    ld[0] = 1'b1; en[0] = 1'b1; up[0] = 1'b1; din[0] = 16'h1234;
    tick(); check("load_prio", 32'(q4), 32'h1234); check("load_ok_lerr", 32'(le[0]), 32'h0);
    din[0] = 16'h12A4;
    tick(); check("load_reject_q", 32'(q4), 32'h1234); check("load_reject_lerr", 32'(le[0]), 32'h1);
    ld[0] = 1'b0; en[0] = 1'b0;
    tick(); check("load_err_clear", 32'(le[0]), 32'h0);

    // cascade of two single-decade stages
    check("cascade_start", 32'({hi_q, lo_q}), 32'h00);
    c_en = 1'b1;
    hw_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("cascade_count", 32'({hi_q, lo_q}), 32'(to_bcd(k % 100, 2)));
      if (hi_wr) hw_cnt++;
    end
    c_en = 1'b0;
    check("cascade_hi_wraps", 32'(hw_cnt), 32'd1);

    // randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      tick();
      if (it == 1500) begin
        #1 rst = 1'b1;
      end else if (rst) begin
        rst = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        ld[k] = ($urandom_range(0, 11) == 0);
        case ($urandom_range(0, 3))
          0: din[k] = 16'($urandom);
          1: din[k] = to_bcd(($urandom_range(0, 1) == 0) ? md(k) - 1 - $urandom_range(0, 2)
                                                          : $urandom_range(0, 2), nd(k));
          default: din[k] = to_bcd($urandom_range(0, md(k) - 1), nd(k));
        endcase
        en[k] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) up[k] = ~up[k];
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
